// File: rtl/asic_output_classifier.sv
// Window-averaging classifier for four measured neuron levels: picks the strongest
// channel per window and only changes its reported decision after repeated agreement.
module asic_output_classifier #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LOG2_WINDOW  = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] aux0,
  input  logic [SAMPLE_WIDTH-1:0] aux1,
  input  logic [SAMPLE_WIDTH-1:0] aux2,
  input  logic [SAMPLE_WIDTH-1:0] aux3,
  input  logic [SAMPLE_WIDTH-1:0] threshold,
  output logic [1:0]              network_output,
  output logic                    output_valid,
  output logic                    no_winner,
  output logic                    window_done,
  output logic [SAMPLE_WIDTH-1:0] max_avg
);

  localparam int ACC_W = SAMPLE_WIDTH + LOG2_WINDOW;
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);
  // bit 2 set marks "no channel reached threshold"
  localparam logic [2:0] CAND_NONE = 3'b100;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, UPDATE} state_t;

  state_t                  state;
  logic [ACC_W-1:0]        acc [4];
  logic [SAMPLE_WIDTH-1:0] aux [4];
  logic [SAMPLE_WIDTH-1:0] avg [4];
  logic [LOG2_WINDOW-1:0]  sample_cnt;
  logic [2:0]              prev_cand;
  logic [3:0]              stable_cnt;
  logic [3:0]              stable_next;
  logic [1:0]              best_idx;
  logic [SAMPLE_WIDTH-1:0] best_avg;
  logic [2:0]              cand_p1;
  logic [SAMPLE_WIDTH-1:0] max_p1;

  function automatic logic [SAMPLE_WIDTH-1:0] win_avg(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:LOG2_WINDOW];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt >= STABLE_MAX) return STABLE_MAX;
    return cnt + 4'd1;
  endfunction

  assign aux[0] = aux0;
  assign aux[1] = aux1;
  assign aux[2] = aux2;
  assign aux[3] = aux3;

  // strict '>' keeps the lowest index on ties
  always_comb begin
    for (int i = 0; i < 4; i++) avg[i] = win_avg(acc[i]);
    best_idx = 2'd0;
    best_avg = avg[0];
    for (int i = 1; i < 4; i++) begin
      if (avg[i] > best_avg) begin
        best_avg = avg[i];
        best_idx = 2'(i);
      end
    end
  end

  always_comb begin
    stable_next = 4'd1;
    if (cand_p1 == prev_cand) stable_next = sat_inc(stable_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      sample_cnt     <= '0;
      stable_cnt     <= 4'd0;
      prev_cand      <= CAND_NONE;
      network_output <= 2'b00;
      output_valid   <= 1'b0;
      no_winner      <= 1'b0;
      window_done    <= 1'b0;
      max_avg        <= '0;
    end else begin
      window_done <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        for (int i = 0; i < 4; i++) acc[i] <= '0;
        sample_cnt <= '0;
      end else begin
        case (state)
          IDLE: state <= ACCUM;
          // ---- stage p0: window accumulation
          ACCUM: begin
            if (sample_valid) begin
              for (int i = 0; i < 4; i++) acc[i] <= acc[i] + ACC_W'(aux[i]);
              sample_cnt <= sample_cnt + LOG2_WINDOW'(1);
              if (sample_cnt == '1) state <= COMPARE;
            end
          end
          // ---- stage p1: average, argmax and threshold
          COMPARE: begin
            cand_p1 <= (best_avg >= threshold) ? {1'b0, best_idx} : CAND_NONE;
            max_p1  <= best_avg;
            state   <= UPDATE;
          end
          // ---- stage p2: hysteresis and output update
          UPDATE: begin
            stable_cnt  <= stable_next;
            prev_cand   <= cand_p1;
            max_avg     <= max_p1;
            window_done <= 1'b1;
            if (stable_next == STABLE_MAX) begin
              if (cand_p1[2]) begin
                no_winner    <= 1'b1;
                output_valid <= 1'b0;
              end else begin
                network_output <= cand_p1[1:0];
                output_valid   <= 1'b1;
                no_winner      <= 1'b0;
              end
            end
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            sample_cnt <= '0;
            state      <= ACCUM;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_asic_output_classifier.sv
// Bench for asic_output_classifier: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a window-level behavioural model.
module tb_asic_output_classifier;

  localparam int SW = 12;
  localparam int LW = 2;
  localparam int SC = 2;
  localparam int WIN = 1 << LW;

  logic          clk = 1'b0;
  logic          rst, enable, sample_valid;
  logic [SW-1:0] aux0, aux1, aux2, aux3, threshold;
  logic [1:0]    network_output;
  logic          output_valid, no_winner, window_done;
  logic [SW-1:0] max_avg;

  always #5 clk = ~clk;

  asic_output_classifier #(.SAMPLE_WIDTH(SW), .LOG2_WINDOW(LW), .STABLE_COUNT(SC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .aux0(aux0), .aux1(aux1), .aux2(aux2), .aux3(aux3), .threshold(threshold),
    .network_output(network_output), .output_valid(output_valid),
    .no_winner(no_winner), .window_done(window_done), .max_avg(max_avg)
  );

  int checks = 0;
  int failures = 0;
  int wd_count = 0;

  // model: accepted samples are summed; after a full window the decision lands
  // two cycles later, during which samples are ignored
  bit mvalid = 0;
  bit m_idle;
  int m_busy, m_n, m_prev, m_stable, m_cand, m_max;
  int m_sum [4];
  int e_net, e_ov, e_nw, e_wd, e_max;

  function automatic void classify();
    int a;
    m_max = -1;
    m_cand = 0;
    for (int i = 0; i < 4; i++) begin
      a = m_sum[i] / WIN;
      if (a > m_max) begin
        m_max = a;
        m_cand = i;
      end
    end
    if (m_max < int'(threshold)) m_cand = 4;
  endfunction

  function automatic void apply_decision();
    if (m_cand == m_prev) m_stable = (m_stable + 1 > SC) ? SC : m_stable + 1;
    else begin
      m_stable = 1;
      m_prev = m_cand;
    end
    e_wd = 1;
    e_max = m_max;
    if (m_stable == SC) begin
      if (m_cand == 4) begin
        e_nw = 1;
        e_ov = 0;
      end else begin
        e_net = m_cand;
        e_ov = 1;
        e_nw = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    e_wd = 0;
    if (rst) begin
      mvalid = 1;
      m_idle = 1;
      m_busy = 0;
      m_n = 0;
      m_prev = 4;
      m_stable = 0;
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
      e_net = 0; e_ov = 0; e_nw = 0; e_max = 0;
    end else if (!mvalid) begin
      m_idle = 1;
    end else if (!enable) begin
      m_idle = 1;
      m_busy = 0;
      m_n = 0;
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
    end else if (m_idle) begin
      m_idle = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) apply_decision();
    end else if (sample_valid) begin
      m_sum[0] += int'(aux0);
      m_sum[1] += int'(aux1);
      m_sum[2] += int'(aux2);
      m_sum[3] += int'(aux3);
      m_n++;
      if (m_n == WIN) begin
        classify();
        m_n = 0;
        for (int i = 0; i < 4; i++) m_sum[i] = 0;
        m_busy = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (network_output !== 2'(e_net) || output_valid !== 1'(e_ov) || no_winner !== 1'(e_nw) ||
          window_done !== 1'(e_wd) || max_avg !== SW'(e_max)) begin
        failures++;
        $display("FAIL model_cycle t=%0t got net=%0d ov=%b nw=%b wd=%b max=%h required net=%0d ov=%0d nw=%0d wd=%0d max=%h",
                 $time, network_output, output_valid, no_winner, window_done, max_avg,
                 e_net, e_ov, e_nw, e_wd, e_max);
      end
      if (window_done === 1'b1) wd_count++;
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aux(input logic [SW-1:0] a0, a1, a2, a3);
    aux0 = a0; aux1 = a1; aux2 = a2; aux3 = a3;
  endtask

  // n samples back to back, then three quiet cycles so the decision is visible
  task automatic send_window(input logic [SW-1:0] a0, a1, a2, a3, input int n);
    set_aux(a0, a1, a2, a3);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_lit({tag, "_net"}, 32'(network_output), 32'd0);
    check_lit({tag, "_ov"}, 32'(output_valid), 32'd0);
    check_lit({tag, "_nw"}, 32'(no_winner), 32'd0);
    check_lit({tag, "_wd"}, 32'(window_done), 32'd0);
    check_lit({tag, "_max"}, 32'(max_avg), 32'd0);
  endtask

  int base;

  initial begin
    rst = 1'b0; enable = 1'b0; sample_valid = 1'b0; threshold = 12'h100;
    set_aux(0, 0, 0, 0);
    tick();
    do_reset();
    check_reset_outputs("reset");
    enable = 1'b1;
    tick();

    // two identical windows confirm channel 1
    base = wd_count;
    send_window(12'h050, 12'h300, 12'h080, 12'h020, WIN);
    check_lit("win1_ov", 32'(output_valid), 32'd0);
    check_lit("win1_wd_count", 32'(wd_count - base), 32'd1);
    send_window(12'h050, 12'h300, 12'h080, 12'h020, WIN);
    check_lit("win2_wd_count", 32'(wd_count - base), 32'd2);
    check_lit("win2_net", 32'(network_output), 32'd1);
    check_lit("win2_ov", 32'(output_valid), 32'd1);
    check_lit("win2_max", 32'(max_avg), 32'h300);

    // single channel-3 window does not displace the confirmed winner
    send_window(12'h050, 12'h100, 12'h080, 12'h400, WIN);
    check_lit("hyst_ch3_net", 32'(network_output), 32'd1);
    check_lit("hyst_ch3_max", 32'(max_avg), 32'h400);
    send_window(12'h050, 12'h300, 12'h080, 12'h020, WIN);
    check_lit("hyst_ch1_net", 32'(network_output), 32'd1);
    check_lit("hyst_ch1_ov", 32'(output_valid), 32'd1);

    // tie goes to the lower index
    send_window(12'h200, 12'h010, 12'h200, 12'h010, WIN);
    send_window(12'h200, 12'h010, 12'h200, 12'h010, WIN);
    check_lit("tie_net", 32'(network_output), 32'd0);

    // just below threshold everywhere, then exactly at threshold on channel 2
    send_window(12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, WIN);
    send_window(12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, WIN);
    check_lit("below_nw", 32'(no_winner), 32'd1);
    check_lit("below_ov", 32'(output_valid), 32'd0);
    check_lit("below_net", 32'(network_output), 32'd0);
    send_window(12'h000, 12'h000, 12'h100, 12'h000, WIN);
    send_window(12'h000, 12'h000, 12'h100, 12'h000, WIN);
    check_lit("at_thr_net", 32'(network_output), 32'd2);
    check_lit("at_thr_ov", 32'(output_valid), 32'd1);
    check_lit("at_thr_nw", 32'(no_winner), 32'd0);

    // continuous strobe: the two busy cycles carry 0xFFF, which must be dropped
    base = wd_count;
    sample_valid = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WIN; i++) begin
        set_aux((i == 0) ? 12'h001 : 12'h002, 12'h000, 12'h000, 12'h000);
        tick();
      end
      set_aux(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      tick();
      tick();
    end
    sample_valid = 1'b0;
    set_aux(0, 0, 0, 0);
    tick();
    check_lit("stream_wd_count", 32'(wd_count - base), 32'd2);
    check_lit("stream_max", 32'(max_avg), 32'h001);
    check_lit("stream_nw", 32'(no_winner), 32'd1);

    // partial window then reset
    base = wd_count;
    send_window(12'h000, 12'hFFF, 12'h000, 12'h000, 3);
    rst = 1'b1;
    sample_valid = 1'b1;
    tick();
    rst = 1'b0;
    sample_valid = 1'b0;
    check_reset_outputs("mid_rst");
    check_lit("mid_rst_wd_count", 32'(wd_count - base), 32'd0);
    tick();

    // partial window then enable drop
    send_window(12'h000, 12'hFFF, 12'h000, 12'h000, 3);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check_lit("en_drop_wd_count", 32'(wd_count - base), 32'd0);
    send_window(12'h000, 12'h300, 12'h000, 12'h000, WIN);
    check_lit("fresh_wd_count", 32'(wd_count - base), 32'd1);
    check_lit("fresh_max", 32'(max_avg), 32'h300);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      int bias;
      logic [SW-1:0] v [4];
      bias = (c / 40) % 4;
      rst = ($urandom_range(0, 399) == 0);
      enable = ($urandom_range(0, 59) != 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0: v[i] = 12'h100;
          1: v[i] = 12'h0FF;
          2: v[i] = SW'($urandom_range(0, 12'hFFF));
          default: v[i] = SW'($urandom_range(0, 12'h0C0));
        endcase
      end
      if ($urandom_range(0, 2) != 0) v[bias] = SW'($urandom_range(12'h0E0, 12'h3FF));
      set_aux(v[0], v[1], v[2], v[3]);
      tick();
    end
    rst = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
